// File: rtl/rx_pkt_len_tagger.sv
// rx_pkt_len_tagger: store-and-forward stage behind the RX AXI-Stream master.
// Whole packets are buffered while their byte length is counted from tstrb.
// Each packet is then re-emitted with the length in tuser[C_LEN_WIDTH-1:0].
// Packets that cannot fit are dropped whole and counted.
module rx_pkt_len_tagger #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DATA_DEPTH_LOG2  = 6,
    parameter int C_META_DEPTH_LOG2  = 4,
    parameter int C_LEN_WIDTH        = 16
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       pkt_fwd_cnt,
    output logic [31:0]                       pkt_drop_cnt
);

    localparam int STRB_W     = C_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W    = C_AXIS_DATA_WIDTH + STRB_W + 1;
    localparam int DATA_DEPTH = 1 << C_DATA_DEPTH_LOG2;
    localparam int META_DEPTH = 1 << C_META_DEPTH_LOG2;
    localparam int DPTR_W     = C_DATA_DEPTH_LOG2 + 1;
    localparam int MCNT_W     = C_META_DEPTH_LOG2 + 1;
    localparam int UHI_W      = C_AXIS_TUSER_WIDTH - C_LEN_WIDTH;

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_PKT} rd_state_t;

    // Storage: beats as {tdata, tstrb, tlast}, packet metadata as finished tuser.
    logic [ENTRY_W-1:0]            data_mem [DATA_DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_mem [META_DEPTH];

    // Write side state.
    wr_state_t                wr_state_q, wr_state_d;
    logic [DPTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DPTR_W-1:0]        start_ptr_q, start_ptr_d;
    logic [C_LEN_WIDTH-1:0]   len_q, len_d;
    logic [UHI_W-1:0]         tuser_hi_q, tuser_hi_d;
    logic [31:0]              drop_cnt_q, drop_cnt_d;
    logic                     s_ready_q;
    logic                     data_we;
    logic                     meta_push;
    logic [C_LEN_WIDTH-1:0]   push_len;
    logic [UHI_W-1:0]         push_hi;

    // Meta FIFO bookkeeping.
    logic [C_META_DEPTH_LOG2-1:0] meta_wr_ptr_q, meta_wr_ptr_d;
    logic [C_META_DEPTH_LOG2-1:0] meta_rd_ptr_q, meta_rd_ptr_d;
    logic [C_META_DEPTH_LOG2-1:0] meta_rd_ptr_nxt;
    logic [MCNT_W-1:0]            meta_cnt_q, meta_cnt_d;
    logic                         meta_seen_q, meta_seen_d;
    logic                         meta_full, meta_empty, meta_pop;

    // Read side state and output register.
    rd_state_t                     rd_state_q, rd_state_d;
    logic [DPTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [C_AXIS_DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic [STRB_W-1:0]             m_tstrb_q, m_tstrb_d;
    logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic                          m_tvalid_q, m_tvalid_d;
    logic                          m_tlast_q, m_tlast_d;
    logic [31:0]                   fwd_cnt_q, fwd_cnt_d;
    logic                          load_beat;

    logic                 beat_accept;
    logic [C_LEN_WIDTH-1:0] beat_len;
    logic [DPTR_W-1:0]    data_occ;
    logic                 data_full;
    logic [ENTRY_W-1:0]   rd_entry;
    logic                 unused_tuser_lo;

    function automatic logic [C_LEN_WIDTH-1:0] popcount(input logic [STRB_W-1:0] s);
        logic [C_LEN_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < STRB_W; i++) begin
            c = c + C_LEN_WIDTH'(s[i]);
        end
        return c;
    endfunction

    assign unused_tuser_lo = ^s_axis_tuser[C_LEN_WIDTH-1:0];
    assign beat_accept     = s_axis_tvalid && s_ready_q;
    assign beat_len        = popcount(s_axis_tstrb);
    assign data_occ        = wr_ptr_q - rd_ptr_q;
    assign data_full       = (data_occ == DPTR_W'(DATA_DEPTH));
    assign meta_full       = (meta_cnt_q == MCNT_W'(META_DEPTH));
    assign meta_empty      = (meta_cnt_q == '0);
    assign meta_rd_ptr_nxt = meta_rd_ptr_q + 1'b1;
    assign rd_entry        = data_mem[rd_ptr_q[C_DATA_DEPTH_LOG2-1:0]];

    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tstrb  = m_tstrb_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign pkt_fwd_cnt   = fwd_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;

    // Write FSM next state: store, rewind or discard each accepted beat.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        len_d       = len_q;
        tuser_hi_d  = tuser_hi_q;
        drop_cnt_d  = drop_cnt_q;
        data_we     = 1'b0;
        meta_push   = 1'b0;
        push_len    = len_q;
        push_hi     = tuser_hi_q;
        if (beat_accept) begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (meta_full || data_full) begin
                        if (s_axis_tlast) drop_cnt_d = drop_cnt_q + 32'd1;
                        else              wr_state_d = WR_DROP;
                    end else begin
                        data_we     = 1'b1;
                        wr_ptr_d    = wr_ptr_q + 1'b1;
                        start_ptr_d = wr_ptr_q;
                        len_d       = beat_len;
                        tuser_hi_d  = s_axis_tuser[C_AXIS_TUSER_WIDTH-1:C_LEN_WIDTH];
                        if (s_axis_tlast) begin
                            meta_push = 1'b1;
                            push_len  = beat_len;
                            push_hi   = s_axis_tuser[C_AXIS_TUSER_WIDTH-1:C_LEN_WIDTH];
                        end else begin
                            wr_state_d = WR_PKT;
                        end
                    end
                end
                WR_PKT: begin
                    if (data_full) begin
                        wr_ptr_d = start_ptr_q;
                        if (s_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            wr_state_d = WR_IDLE;
                        end else begin
                            wr_state_d = WR_DROP;
                        end
                    end else begin
                        data_we  = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_q + beat_len;
                        if (s_axis_tlast) begin
                            meta_push  = 1'b1;
                            push_len   = len_q + beat_len;
                            wr_state_d = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        wr_state_d = WR_IDLE;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // Write FSM registers; tready comes up on the first clock out of reset.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_state_q  <= WR_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            len_q       <= '0;
            tuser_hi_q  <= '0;
            drop_cnt_q  <= '0;
            s_ready_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            len_q       <= len_d;
            tuser_hi_q  <= tuser_hi_d;
            drop_cnt_q  <= drop_cnt_d;
            s_ready_q   <= 1'b1;
        end
    end

    // Buffer RAMs are not reset; the cleared pointers make their contents dead.
    always_ff @(posedge axi_aclk) begin
        if (data_we) data_mem[wr_ptr_q[C_DATA_DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tstrb, s_axis_tlast};
        if (meta_push) meta_mem[meta_wr_ptr_q] <= {push_hi, push_len};
    end

    // Meta FIFO count; meta_seen_q holds off the read side one cycle after a commit.
    always_comb begin
        meta_wr_ptr_d = meta_wr_ptr_q;
        meta_cnt_d    = meta_cnt_q;
        meta_seen_d   = !meta_empty;
        if (meta_push) meta_wr_ptr_d = meta_wr_ptr_q + 1'b1;
        if (meta_push && !meta_pop)      meta_cnt_d = meta_cnt_q + 1'b1;
        else if (!meta_push && meta_pop) meta_cnt_d = meta_cnt_q - 1'b1;
    end

    // Meta FIFO registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            meta_wr_ptr_q <= '0;
            meta_cnt_q    <= '0;
            meta_seen_q   <= 1'b0;
        end else begin
            meta_wr_ptr_q <= meta_wr_ptr_d;
            meta_cnt_q    <= meta_cnt_d;
            meta_seen_q   <= meta_seen_d;
        end
    end

    // Read FSM next state: hold the output beat until taken, then stream the next.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_ptr_d      = rd_ptr_q;
        meta_rd_ptr_d = meta_rd_ptr_q;
        m_tdata_d     = m_tdata_q;
        m_tstrb_d     = m_tstrb_q;
        m_tuser_d     = m_tuser_q;
        m_tvalid_d    = m_tvalid_q;
        m_tlast_d     = m_tlast_q;
        fwd_cnt_d     = fwd_cnt_q;
        meta_pop      = 1'b0;
        load_beat     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (meta_seen_q && !meta_empty) begin
                    load_beat  = 1'b1;
                    m_tuser_d  = meta_mem[meta_rd_ptr_q];
                    m_tvalid_d = 1'b1;
                    rd_state_d = RD_PKT;
                end
            end
            RD_PKT: begin
                if (m_axis_tready) begin
                    if (m_tlast_q) begin
                        meta_pop      = 1'b1;
                        meta_rd_ptr_d = meta_rd_ptr_nxt;
                        fwd_cnt_d     = fwd_cnt_q + 32'd1;
                        if (meta_cnt_q > MCNT_W'(1)) begin
                            load_beat = 1'b1;
                            m_tuser_d = meta_mem[meta_rd_ptr_nxt];
                        end else begin
                            m_tvalid_d = 1'b0;
                            rd_state_d = RD_IDLE;
                        end
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
        endcase
        if (load_beat) begin
            m_tdata_d = rd_entry[ENTRY_W-1 -: C_AXIS_DATA_WIDTH];
            m_tstrb_d = rd_entry[STRB_W:1];
            m_tlast_d = rd_entry[0];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
    end

    // Read FSM registers and the m_axis output register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_state_q    <= RD_IDLE;
            rd_ptr_q      <= '0;
            meta_rd_ptr_q <= '0;
            m_tdata_q     <= '0;
            m_tstrb_q     <= '0;
            m_tuser_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            fwd_cnt_q     <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_ptr_q      <= rd_ptr_d;
            meta_rd_ptr_q <= meta_rd_ptr_d;
            m_tdata_q     <= m_tdata_d;
            m_tstrb_q     <= m_tstrb_d;
            m_tuser_q     <= m_tuser_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            fwd_cnt_q     <= fwd_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_pkt_len_tagger.sv
// tb_rx_pkt_len_tagger: directed bench for rx_pkt_len_tagger.
// Drives inputs #1 after the rising edge, records output handshakes on the falling edge.
module tb_rx_pkt_len_tagger;

    logic         axi_aclk = 1'b0;
    logic         axi_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_fwd_cnt;
    logic [31:0]  pkt_drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int cap_n        = 0;
    logic [255:0] cap_data [$];
    logic [31:0]  cap_strb [$];
    logic [127:0] cap_user [$];
    logic         cap_last [$];
    int           cap_cyc  [$];

    int           base;
    int           k;
    logic [127:0] u;
    logic [31:0]  strb_v;

    rx_pkt_len_tagger dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_fwd_cnt   (pkt_fwd_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt)
    );

    // Free-running 100 MHz clock.
    always #5 axi_aclk = ~axi_aclk;

    // Cycle counter used to timestamp output handshakes.
    always @(posedge axi_aclk) cyc <= cyc + 1;

    // Record every beat that will be handshaken at the coming rising edge.
    always @(negedge axi_aclk) begin
        if (axi_resetn && m_axis_tvalid && m_axis_tready) begin
            cap_data.push_back(m_axis_tdata);
            cap_strb.push_back(m_axis_tstrb);
            cap_user.push_back(m_axis_tuser);
            cap_last.push_back(m_axis_tlast);
            cap_cyc.push_back(cyc);
            cap_n = cap_n + 1;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [255:0] mkData(input int pkt, input int beat);
        logic [31:0] w;
        w = {pkt[15:0], beat[15:0]};
        return {8{w}};
    endfunction

    function automatic logic [127:0] mkUser(input int pkt);
        logic [31:0] p;
        p = pkt;
        return {p, 64'h0123_4567_89AB_CDEF, 16'h0104, 16'hBEEF};
    endfunction

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic idleInput();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
    endtask

    task automatic applyStimulus(input logic [255:0] d, input logic [31:0] strb,
                                 input logic [127:0] user, input logic last);
        s_axis_tdata  = d;
        s_axis_tstrb  = strb;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        tick();
    endtask

    task automatic sendPacket(input int pkt, input int nbeats, input logic [31:0] strb);
        for (int b = 0; b < nbeats; b++) begin
            applyStimulus(mkData(pkt, b), strb, mkUser(pkt), (b == nbeats - 1));
        end
        idleInput();
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCaptures(input int n, input int budget);
        int w;
        w = 0;
        while (cap_n < n && w < budget) begin
            tick();
            w++;
        end
        checkOutput("capture_count", cap_n, n);
    endtask

    task automatic waitValid(input int budget);
        int w;
        w = 0;
        while (!m_axis_tvalid && w < budget) begin
            tick();
            w++;
        end
        checkOutput("wait_tvalid", m_axis_tvalid, 1'b1);
    endtask

    // Directed sequence: reset, then the six scenarios in order.
    initial begin
        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        idleInput();

        // Reset state.
        tick();
        checkOutput("rst_s_tready", s_axis_tready, 1'b0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_m_tdata", m_axis_tdata, '0);
        checkOutput("rst_m_tuser", m_axis_tuser, '0);
        checkOutput("rst_fwd_cnt", pkt_fwd_cnt, '0);
        checkOutput("rst_drop_cnt", pkt_drop_cnt, '0);
        repeat (2) tick();
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        tick();
        checkOutput("rel_s_tready", s_axis_tready, 1'b1);

        // 1: one-beat packet, 16 bytes, latency of two cycles after the tlast edge.
        m_axis_tready = 1'b1;
        u = mkUser(1);
        applyStimulus(mkData(1, 0), 32'h0000FFFF, u, 1'b1);
        idleInput();
        checkOutput("t1_valid_e0", m_axis_tvalid, 1'b0);
        tick();
        checkOutput("t1_valid_e1", m_axis_tvalid, 1'b0);
        tick();
        checkOutput("t1_valid_e2", m_axis_tvalid, 1'b1);
        checkOutput("t1_len", m_axis_tuser[15:0], 16'd16);
        checkOutput("t1_user_31_16", m_axis_tuser[31:16], 16'h0104);
        checkOutput("t1_user", m_axis_tuser, {u[127:16], 16'd16});
        checkOutput("t1_data", m_axis_tdata, mkData(1, 0));
        checkOutput("t1_last", m_axis_tlast, 1'b1);
        tick();
        checkOutput("t1_valid_done", m_axis_tvalid, 1'b0);
        checkOutput("t1_fwd_cnt", pkt_fwd_cnt, 32'd1);

        // 2: two beats, 32 + 28 bytes = 60, streamed back-to-back.
        base = cap_n;
        u = mkUser(2);
        applyStimulus(mkData(2, 0), 32'hFFFFFFFF, u, 1'b0);
        applyStimulus(mkData(2, 1), 32'h0FFFFFFF, u, 1'b1);
        idleInput();
        waitCaptures(base + 2, 20);
        if (cap_n >= base + 2) begin
            checkOutput("t2_data0", cap_data[base], mkData(2, 0));
            checkOutput("t2_user0", cap_user[base], {u[127:16], 16'd60});
            checkOutput("t2_last0", cap_last[base], 1'b0);
            checkOutput("t2_data1", cap_data[base+1], mkData(2, 1));
            checkOutput("t2_strb1", cap_strb[base+1], 32'h0FFFFFFF);
            checkOutput("t2_user1", cap_user[base+1], {u[127:16], 16'd60});
            checkOutput("t2_last1", cap_last[base+1], 1'b1);
            checkOutput("t2_back_to_back", cap_cyc[base+1] - cap_cyc[base], 1);
        end
        tick();
        checkOutput("t2_fwd_cnt", pkt_fwd_cnt, 32'd2);

        // 3: stall tready for 10 cycles on the middle beat of a 3-beat packet.
        m_axis_tready = 1'b0;
        base = cap_n;
        u = mkUser(3);
        sendPacket(3, 3, 32'hFFFFFFFF);
        waitValid(20);
        checkOutput("t3_first_beat", m_axis_tdata, mkData(3, 0));
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t3_hold_data", m_axis_tdata, mkData(3, 1));
            checkOutput("t3_hold_last", m_axis_tlast, 1'b0);
        end
        checkOutput("t3_hold_user", m_axis_tuser, {u[127:16], 16'd96});
        checkOutput("t3_hold_strb", m_axis_tstrb, 32'hFFFFFFFF);
        checkOutput("t3_hold_valid", m_axis_tvalid, 1'b1);
        m_axis_tready = 1'b1;
        waitCaptures(base + 3, 20);
        if (cap_n >= base + 3) begin
            checkOutput("t3_cap0", cap_data[base], mkData(3, 0));
            checkOutput("t3_cap1", cap_data[base+1], mkData(3, 1));
            checkOutput("t3_cap2", cap_data[base+2], mkData(3, 2));
            checkOutput("t3_cap2_last", cap_last[base+2], 1'b1);
        end
        repeat (3) tick();
        checkOutput("t3_no_dup", cap_n, base + 3);
        checkOutput("t3_fwd_cnt", pkt_fwd_cnt, 32'd3);

        // 4a: three 30-beat packets into a stalled output; the third overflows.
        m_axis_tready = 1'b0;
        base = cap_n;
        sendPacket(10, 30, 32'hFFFFFFFF);
        sendPacket(11, 30, 32'hFFFFFFFF);
        sendPacket(12, 30, 32'hFFFFFFFF);
        repeat (4) tick();
        checkOutput("t4_drop_cnt", pkt_drop_cnt, 32'd1);
        checkOutput("t4_none_out", cap_n, base);
        m_axis_tready = 1'b1;
        waitCaptures(base + 60, 200);
        if (cap_n >= base + 60) begin
            checkOutput("t4_p10_first", cap_data[base], mkData(10, 0));
            checkOutput("t4_p10_len", cap_user[base], {mkUser(10) >> 16, 16'd960});
            checkOutput("t4_p10_last", cap_data[base+29], mkData(10, 29));
            checkOutput("t4_p10_tlast", cap_last[base+29], 1'b1);
            checkOutput("t4_p11_first", cap_data[base+30], mkData(11, 0));
            checkOutput("t4_p11_end", cap_data[base+59], mkData(11, 29));
            checkOutput("t4_p11_tlast", cap_last[base+59], 1'b1);
        end
        repeat (5) tick();
        checkOutput("t4_no_p12", cap_n, base + 60);
        checkOutput("t4_fwd_cnt", pkt_fwd_cnt, 32'd5);

        // 4b: a 65-beat packet can never fit.
        base = cap_n;
        sendPacket(20, 65, 32'hFFFFFFFF);
        repeat (5) tick();
        checkOutput("t4_long_drop", pkt_drop_cnt, 32'd2);
        checkOutput("t4_long_none", cap_n, base);
        checkOutput("t4_long_fwd", pkt_fwd_cnt, 32'd5);

        // 5: 17 one-beat packets with output stalled; meta FIFO holds 16.
        m_axis_tready = 1'b0;
        base = cap_n;
        for (int i = 0; i < 17; i++) begin
            strb_v = (32'h1 << (i + 1)) - 32'h1;
            applyStimulus(mkData(50 + i, 0), strb_v, mkUser(50 + i), 1'b1);
        end
        idleInput();
        repeat (4) tick();
        checkOutput("t5_drop_cnt", pkt_drop_cnt, 32'd3);
        m_axis_tready = 1'b1;
        waitCaptures(base + 16, 100);
        if (cap_n >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                checkOutput("t5_order_data", cap_data[base+i], mkData(50 + i, 0));
                checkOutput("t5_len", cap_user[base+i][15:0], i + 1);
            end
        end
        repeat (4) tick();
        checkOutput("t5_no_17th", cap_n, base + 16);
        checkOutput("t5_fwd_cnt", pkt_fwd_cnt, 32'd21);

        // 6: reset while a packet is held at the output and another is half written.
        m_axis_tready = 1'b0;
        sendPacket(60, 2, 32'hFFFFFFFF);
        applyStimulus(mkData(61, 0), 32'hFFFFFFFF, mkUser(61), 1'b0);
        idleInput();
        repeat (3) tick();
        checkOutput("t6_pre_valid", m_axis_tvalid, 1'b1);
        #2;
        axi_resetn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", m_axis_tvalid, 1'b0);
        checkOutput("t6_rst_data", m_axis_tdata, '0);
        checkOutput("t6_rst_strb", m_axis_tstrb, '0);
        checkOutput("t6_rst_user", m_axis_tuser, '0);
        checkOutput("t6_rst_last", m_axis_tlast, 1'b0);
        checkOutput("t6_rst_s_tready", s_axis_tready, 1'b0);
        checkOutput("t6_rst_fwd", pkt_fwd_cnt, '0);
        checkOutput("t6_rst_drop", pkt_drop_cnt, '0);
        repeat (2) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        checkOutput("t6_s_tready", s_axis_tready, 1'b1);
        base = cap_n;
        u = mkUser(62);
        applyStimulus(mkData(62, 0), 32'h000000F0, u, 1'b1);
        idleInput();
        waitCaptures(base + 1, 10);
        if (cap_n >= base + 1) begin
            checkOutput("t6_data", cap_data[base], mkData(62, 0));
            checkOutput("t6_user", cap_user[base], {u[127:16], 16'd4});
            checkOutput("t6_last", cap_last[base], 1'b1);
        end
        repeat (3) tick();
        checkOutput("t6_only_one", cap_n, base + 1);
        checkOutput("t6_fwd_cnt", pkt_fwd_cnt, 32'd1);
        checkOutput("t6_drop_cnt", pkt_drop_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_pkt_len_tagger.md
Name: rx_pkt_len_tagger

Overview:
Store-and-forward stage directly downstream of the 1G CML interface RX AXI-Stream master (256-bit data, 128-bit tuser). It buffers each complete packet and counts its bytes from tstrb. It then re-emits the packet with the byte length written into tuser[15:0]. Packets that do not fit in the buffer are dropped whole, and drops are counted.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width.
C_DATA_DEPTH_LOG2, 6, log2 of data buffer depth in beats (64 beats).
C_META_DEPTH_LOG2, 4, log2 of metadata FIFO depth in packets (16 packets).
C_LEN_WIDTH, 16, width of the length field inserted at tuser[C_LEN_WIDTH-1:0].

Ports:
axi_aclk  in  1  sole clock.
axi_resetn  in  1  reset, asynchronous, active-low.
s_axis_tdata  in  256  RX beat data from the interface.
s_axis_tstrb  in  32  byte enables.
s_axis_tuser  in  128  metadata, sampled on the first beat only.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  always 1 after reset; this block never back-pressures the MAC.
s_axis_tlast  in  1  last beat of the packet.
m_axis_tdata  out  256  buffered data.
m_axis_tstrb  out  32  buffered byte enables.
m_axis_tuser  out  128  first-beat tuser with [15:0] replaced by the length; driven on every beat of the packet.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat.
pkt_fwd_cnt  out  32  count of forwarded packets; wraps.
pkt_drop_cnt  out  32  count of dropped packets; wraps.

Behaviour:
- Reset (axi_resetn=0, asynchronous):
  - All pointers, FSMs and counters clear.
  - m_axis_tvalid=0; m_axis_tdata, m_axis_tstrb, m_axis_tuser and m_axis_tlast = 0.
  - s_axis_tready=0 while in reset, 1 from the first clock after release.
  - Packets held in the buffer, or partly received, are lost.
- Data buffer: a dual-pointer RAM of 2^C_DATA_DEPTH_LOG2 entries holding {tdata, tstrb, tlast}.
  - Pointer wrap is modulo the depth.
  - Occupancy counts committed and uncommitted beats.
  - The buffer is full when occupancy = depth.
- Meta FIFO: 2^C_META_DEPTH_LOG2 entries of {tuser with length inserted}.
  - Full and empty are taken from the registered count before any same-cycle pop, so a freed slot is not reusable in the cycle it is freed.
- Length: sum of popcount(tstrb) over all beats, C_LEN_WIDTH bits.
  - Any strobe pattern is accepted; tstrb=0 adds 0.
- Write FSM states: WR_IDLE, WR_PKT, WR_DROP. All transitions occur on an accepted beat (s_axis_tvalid).
  - WR_IDLE: if the meta FIFO is full or the data buffer is full, the beat is discarded.
    - With tlast: pkt_drop_cnt+1, stay in WR_IDLE.
    - Without tlast: go to WR_DROP.
  - WR_IDLE, otherwise: write the beat, latch tuser, set start_ptr = wr_ptr, len = popcount.
    - With tlast: commit, stay in WR_IDLE.
    - Without tlast: go to WR_PKT.
  - WR_PKT with the data buffer full: rewind wr_ptr to start_ptr and discard the beat.
    - With tlast: pkt_drop_cnt+1, go to WR_IDLE.
    - Without tlast: go to WR_DROP.
  - WR_PKT, otherwise: write the beat and accumulate len.
    - With tlast: commit, go to WR_IDLE.
  - WR_DROP: discard beats. On tlast, pkt_drop_cnt+1 and go to WR_IDLE.
  - Commit: push {tuser[127:16], len} to the meta FIFO and make the written beats visible to the read side, both at the same clock edge.
  - A packet longer than the buffer depth is always dropped.
- Read FSM states: RD_IDLE, RD_PKT.
  - RD_IDLE: when the meta FIFO is non-empty, load the first beat into the output register, assert m_axis_tvalid, go to RD_PKT.
  - m_axis_tvalid rises 2 cycles after the clock edge that accepts the tlast beat, provided the read side is idle.
  - Output register is a skid-free hold: all m_axis outputs stay stable while tvalid=1 and tready=0.
  - A handshake on a non-last beat loads the next beat with no bubble, giving full throughput.
  - A handshake on the tlast beat pops the meta FIFO and increments pkt_fwd_cnt.
    - If another packet is committed, its first beat follows on the next cycle with no bubble.
    - Otherwise m_axis_tvalid drops to 0 and the FSM returns to RD_IDLE.
- Simultaneous commit and pop is allowed. The meta count is unchanged and the data buffer occupancy updates by writes minus reads.
- Packet order is preserved. Dropped packets never appear on m_axis, in whole or in part.

Test Plan:
1. One-beat packet, tstrb=32'h0000FFFF, tuser[31:16]=16'h0104, m_axis_tready=1 -> one output beat 2 cycles after input, tuser[15:0]=16'd16, tuser[31:16]=16'h0104, tlast=1, pkt_fwd_cnt=1.
2. Two-beat packet with beat 1 tstrb=all-ones and beat 2 tstrb=32'h0FFFFFFF -> length 60 on both output beats, data bit-exact, back-to-back output beats.
3. Hold m_axis_tready=0 for 10 cycles mid-packet -> m_axis_tdata, m_axis_tstrb, m_axis_tuser and m_axis_tlast stay constant, no beat lost or duplicated.
4. m_axis_tready=0; send three 30-beat packets -> first two forwarded after tready=1, third dropped (overflow mid-packet, rewind); pkt_drop_cnt=1. Separately, one 65-beat packet -> dropped, pkt_drop_cnt+1.
5. m_axis_tready=0; send 17 one-beat packets -> 16 buffered, 17th dropped (meta FIFO full); after release pkt_fwd_cnt=16, in original order.
6. Assert axi_resetn low mid-packet on both sides -> all outputs 0 immediately; after release a fresh packet is forwarded correctly and both counters restart from 0.
